step_ctrl: RTL
==============

# step_ctrl

Board-level execution controller for the RV32 core on the FPGA. Takes three raw pushbuttons (step, run, halt) and drives a single clock-enable that freezes, single-steps or free-runs the core. Each button is synchronized, debounced and reduced to a one-cycle press pulse internally. A run/step/halt state machine, with an optional PC breakpoint, converts those pulses into `cpu_en`.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a synchronized button level is accepted. Must be ≥ 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `btn_step` input 1: raw step button, asynchronous, active-high.
- `btn_run` input 1: raw run button, asynchronous, active-high.
- `btn_halt` input 1: raw halt button, asynchronous, active-high.
- `cpu_en` output 1: core clock enable. The core advances one instruction per cycle in which it is high.
- `mode` output 2: current state. 2'b00 HALT, 2'b01 STEP, 2'b10 RUN.
- `en_count` output 32: number of cycles with `cpu_en` high since reset.
- Present only with `STEP_CTRL_BREAKPOINT_EN`:
  - `pc` input 32: the core's current PC.
  - `bp_addr` input 32: breakpoint address.
  - `bp_valid` input 1: breakpoint armed.

## Operation
- **Per-button front end**, identical for all three buttons:
  - 2-flop synchronizer produces `sync`.
  - Counter `cnt` of width $clog2(DEBOUNCE_CYCLES) counts while `sync != deb` and clears to 0 whenever `sync == deb`.
  - When `cnt == DEBOUNCE_CYCLES-1` and `sync != deb`, `deb` takes `sync` and `cnt` clears.
  - `deb_d` is `deb` delayed one cycle. `press = deb & ~deb_d` is high for exactly one cycle per accepted press. Release produces no pulse.
- **State machine**, registered, reset state HALT:
  - HALT: `halt` press stays in HALT. Otherwise a `run` press goes to RUN. Otherwise a `step` press goes to STEP.
  - STEP: lasts exactly one cycle, then HALT unconditionally. Presses during STEP are ignored.
  - RUN: `halt` press goes to HALT. With `STEP_CTRL_BREAKPOINT_EN`, a breakpoint match also goes to HALT. `run` and `step` presses are ignored.
  - Simultaneous presses resolve with priority halt > run > step.
- **`cpu_en`** (combinational from state): high in STEP, and high in RUN unless a breakpoint match is active. Low in HALT.
- **`en_count`**: increments by 1 every cycle `cpu_en` is high and wraps from 0xFFFFFFFF to 0.
- **`mode`**: the state register, driven directly.

## Timing
- Reset values: `cpu_en`=0, `mode`=2'b00, `en_count`=0. All synchronizer flops, `deb`, `deb_d` and `cnt` reset to 0.
- Press latency:
  - A raw level change sampled at edge E (and held) sets `deb` at edge E+1+DEBOUNCE_CYCLES, so `press` is high in the following cycle.
  - The state changes at edge E+2+DEBOUNCE_CYCLES, and `cpu_en` changes in that same cycle.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES cycles, measured after synchronization, produces no press. Bounce restarts the count.
- Holding a button produces one press only. A second press requires a release that is itself debounced.
- Step: exactly one `cpu_en` cycle per accepted step press. `en_count` rises by exactly 1.
- Halt from RUN: `cpu_en` drops in the cycle after the halt press.
- Reset asserted mid-RUN or mid-STEP: HALT and `cpu_en`=0 from the next edge. An in-progress debounce is discarded.

## Configuration
- **`STEP_CTRL_BREAKPOINT_EN` defined:**
  - Breakpoint ports exist. `bp_match = bp_valid & (pc == bp_addr) & ~skip`.
  - In RUN, `bp_match` forces `cpu_en` low in the same cycle, so the instruction at `bp_addr` does not execute, and the state goes to HALT at the next edge.
  - `skip` is a register. It is set on the transition HALT→RUN and cleared after the first RUN cycle. This lets resume from `bp_addr` execute that instruction.
  - STEP ignores breakpoints.
- **`STEP_CTRL_BREAKPOINT_EN` undefined:** the breakpoint ports and `skip` are absent, and RUN ends only on a halt press.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset:** hold `rst_n`=0 for 3 cycles, then release. `mode`=00, `cpu_en`=0, `en_count`=0 must hold for 20 idle cycles.
2. **Single step:** `btn_step` high for 10 cycles, then low. Exactly one cycle with `cpu_en`=1 and `mode`=01, 6 edges after the first sampled high; `en_count`=1 afterwards.
3. **Glitch rejection:**
   - `btn_run` high for 2 cycles gives no mode change.
   - `btn_run` bouncing 1,0,1,0 then steady high gives RUN only once 4 stable synced cycles have accumulated.
4. **Run then halt:**
   - Press run, wait 50 cycles, press halt. `cpu_en` is continuous for the RUN interval, then 0.
   - `en_count` equals the number of RUN cycles.
   - Simultaneous run+halt in HALT gives no change.
5. **Breakpoint** (macro defined, `bp_addr`=0x100, `bp_valid`=1, bench drives `pc` = 4 × `en_count`):
   - Run from pc 0 halts with `pc`=0x100; `cpu_en` is low in the match cycle and `en_count`=64.
   - A second run press executes 0x100, continues to 0x104 and onward, and `en_count` continues past 64.
6. **Wrap and reset:**
   - Force `en_count` to 0xFFFFFFFF, then step once; `en_count`=0.
   - Assert `rst_n`=0 during RUN; the next edge gives `mode`=00 and `cpu_en`=0.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: turns three raw pushbuttons into a run/step/halt clock enable for the core.
// Define STEP_CTRL_BREAKPOINT_EN to add the PC breakpoint ports and the halt-on-match logic.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        btn_halt,
`ifdef STEP_CTRL_BREAKPOINT_EN
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
`endif
    output logic        cpu_en,
    output logic [1:0]  mode,
    output logic [31:0] en_count
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    // Bit order {halt, run, step} is shared by btn_raw and press.
    assign btn_raw = {btn_halt, btn_run, btn_step};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic [1:0]       sync_q, sync_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;
            logic             deb_dly_q, deb_dly_d;
            logic             sync;

            assign sync = sync_q[1];

            always_comb begin
                sync_d    = {sync_q[0], btn_raw[gi]};
                cnt_d     = '0;
                deb_d     = deb_q;
                deb_dly_d = deb_q;
                if (sync != deb_q) begin
                    if (cnt_q == CNT_MAX) begin
                        deb_d = sync;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q    <= '0;
                    cnt_q     <= '0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                end else begin
                    sync_q    <= sync_d;
                    cnt_q     <= cnt_d;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_dly_d;
                end
            end

            assign press[gi] = deb_q & ~deb_dly_q;
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] en_count_q, en_count_d;
    logic        bp_hit;

`ifdef STEP_CTRL_BREAKPOINT_EN
    logic skip_q, skip_d;

    // skip lets a resume from the breakpoint address execute that instruction once.
    assign bp_hit = bp_valid & (pc == bp_addr) & ~skip_q;
`else
    assign bp_hit = 1'b0;
`endif

    assign cpu_en   = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~bp_hit);
    assign mode     = state_q;
    assign en_count = en_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (press[2]) begin
                    state_d = ST_HALT;
                end else if (press[1]) begin
                    state_d = ST_RUN;
                end else if (press[0]) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_RUN: begin
                if (press[2] | bp_hit) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
        en_count_d = en_count_q + 32'(cpu_en);
    end

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign skip_d = (state_q == ST_HALT) && (state_d == ST_RUN);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_HALT;
            en_count_q <= '0;
`ifdef STEP_CTRL_BREAKPOINT_EN
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            en_count_q <= en_count_d;
`ifdef STEP_CTRL_BREAKPOINT_EN
            skip_q     <= skip_d;
`endif
        end
    end
endmodule
